// File: rtl/mc_ctrl.sv
// Multi-cycle IF/ID/EXE/MEM/WB sequencing controller producing the state-gated strobes of mycpu_top.
// Optional performance counters are built only when MC_CTRL_PERF_EN is defined.
module mc_ctrl #(
  parameter int IMEM_LAT = 1,
  parameter int DMEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        inst_is_load,
  input  logic        inst_is_store,
  input  logic        inst_gr_we,
  input  logic        br_taken,
  output logic [2:0]  state,
  output logic        inst_sram_en,
  output logic        ir_we,
  output logic        data_sram_en,
  output logic        data_sram_we,
  output logic        rf_we,
  output logic        pc_we,
  output logic        pc_sel_br,
  output logic        retire,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [1:0] IF_LAST  = 2'(IMEM_LAT - 1);
  localparam logic [1:0] MEM_LAST = 2'(DMEM_LAT - 1);

  state_t     r_state;
  state_t     w_nextState;
  logic [1:0] r_wcnt;
  logic [1:0] w_nextWcnt;
  logic       w_ifDone;
  logic       w_memDone;
  logic       w_memOp;

  assign w_ifDone  = (r_wcnt == IF_LAST);
  assign w_memDone = (r_wcnt == MEM_LAST);
  assign w_memOp   = inst_is_load | inst_is_store;
  assign state     = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IF;
      r_wcnt  <= 2'd0;
    end else if (!stall) begin
      r_state <= w_nextState;
      r_wcnt  <= w_nextWcnt;
    end
  end

  // Every state change clears the wait counter, so it always starts at 0 on entry to IF and MEM.
  always_comb begin
    w_nextState = S_IF;
    w_nextWcnt  = 2'd0;
    case (r_state)
      S_IF: begin
        if (w_ifDone) begin
          w_nextState = S_ID;
        end else begin
          w_nextState = S_IF;
          w_nextWcnt  = r_wcnt + 2'd1;
        end
      end
      S_ID:  w_nextState = S_EXE;
      S_EXE: begin
        if (w_memOp)         w_nextState = S_MEM;
        else if (inst_gr_we) w_nextState = S_WB;
        else                 w_nextState = S_IF;
      end
      S_MEM: begin
        if (!w_memDone) begin
          w_nextState = S_MEM;
          w_nextWcnt  = r_wcnt + 2'd1;
        end else if (inst_is_load) begin
          w_nextState = S_WB;
        end else begin
          w_nextState = S_IF;
        end
      end
      S_WB:    w_nextState = S_IF;
      default: w_nextState = S_IF;
    endcase
  end

  // Strobes are suppressed entirely while reset or stall is active; pc_sel_br is 0 whenever pc_we is 0.
  always_comb begin
    inst_sram_en = 1'b0;
    ir_we        = 1'b0;
    data_sram_en = 1'b0;
    data_sram_we = 1'b0;
    rf_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel_br    = 1'b0;
    if (!reset && !stall) begin
      case (r_state)
        S_IF: begin
          inst_sram_en = 1'b1;
          ir_we        = w_ifDone;
        end
        S_EXE: begin
          if (!w_memOp && !inst_gr_we) begin
            pc_we     = 1'b1;
            pc_sel_br = br_taken;
          end
        end
        S_MEM: begin
          data_sram_en = 1'b1;
          data_sram_we = inst_is_store && (r_wcnt == 2'd0);
          if (w_memDone && !inst_is_load) pc_we = 1'b1;
        end
        S_WB: begin
          rf_we     = inst_gr_we;
          pc_we     = 1'b1;
          pc_sel_br = br_taken;
        end
        default: ;
      endcase
    end
    retire = pc_we;
  end

`ifdef MC_CTRL_PERF_EN
  logic [31:0] r_cycleCnt;
  logic [31:0] r_instretCnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycleCnt   <= 32'h0;
      r_instretCnt <= 32'h0;
    end else begin
      r_cycleCnt <= r_cycleCnt + 32'h1;
      if (retire) r_instretCnt <= r_instretCnt + 32'h1;
    end
  end

  assign cycle_cnt   = r_cycleCnt;
  assign instret_cnt = r_instretCnt;
`else
  assign cycle_cnt   = 32'h0;
  assign instret_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: two instances (IMEM/DMEM latency 1/1 and 3/2) against a per-instruction trace model.
// Directed scenarios first, then randomized instructions, stalls and resets.
module tb_mc_ctrl;

  localparam logic [1:0] C_GR = 2'd0;
  localparam logic [1:0] C_LD = 2'd1;
  localparam logic [1:0] C_ST = 2'd2;
  localparam logic [1:0] C_BR = 2'd3;

  typedef struct packed {
    logic [2:0] st;
    logic [7:0] strb;
  } exp_t;

  typedef struct packed {
    logic [1:0] cls;
    logic       br;
    logic       gr;
  } instr_t;

  logic        clk;
  logic        resetIn;
  logic        stallIn [2];
  logic        isLoad  [2];
  logic        isStore [2];
  logic        grWe    [2];
  logic        brTk    [2];
  logic [2:0]  stO     [2];
  logic        ifEnO   [2];
  logic        irWeO   [2];
  logic        dEnO    [2];
  logic        dWeO    [2];
  logic        rfWeO   [2];
  logic        pcWeO   [2];
  logic        pcSelO  [2];
  logic        retO    [2];
  logic [31:0] cycO    [2];
  logic [31:0] insO    [2];

  exp_t        expQ [2][$];
  instr_t      cur [2];
  instr_t      dirList [$];
  int          dirIdx [2];
  logic [31:0] expCyc [2];
  logic [31:0] expRet [2];
  logic        modelValid;
  int          checks;
  int          failures;
  int          cycleNo;

  mc_ctrl #(.IMEM_LAT(1), .DMEM_LAT(1)) dut0 (
    .clk(clk), .reset(resetIn), .stall(stallIn[0]),
    .inst_is_load(isLoad[0]), .inst_is_store(isStore[0]), .inst_gr_we(grWe[0]), .br_taken(brTk[0]),
    .state(stO[0]), .inst_sram_en(ifEnO[0]), .ir_we(irWeO[0]), .data_sram_en(dEnO[0]),
    .data_sram_we(dWeO[0]), .rf_we(rfWeO[0]), .pc_we(pcWeO[0]), .pc_sel_br(pcSelO[0]),
    .retire(retO[0]), .cycle_cnt(cycO[0]), .instret_cnt(insO[0])
  );

  mc_ctrl #(.IMEM_LAT(3), .DMEM_LAT(2)) dut1 (
    .clk(clk), .reset(resetIn), .stall(stallIn[1]),
    .inst_is_load(isLoad[1]), .inst_is_store(isStore[1]), .inst_gr_we(grWe[1]), .br_taken(brTk[1]),
    .state(stO[1]), .inst_sram_en(ifEnO[1]), .ir_we(irWeO[1]), .data_sram_en(dEnO[1]),
    .data_sram_we(dWeO[1]), .rf_we(rfWeO[1]), .pc_we(pcWeO[1]), .pc_sel_br(pcSelO[1]),
    .retire(retO[1]), .cycle_cnt(cycO[1]), .instret_cnt(insO[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int iLat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int dLat(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  // s7 = {inst_sram_en, ir_we, data_sram_en, data_sram_we, rf_we, pc_we, pc_sel_br}; retire mirrors pc_we
  function automatic exp_t mk(input logic [2:0] st, input logic [6:0] s7);
    exp_t e;
    e.st   = st;
    e.strb = {s7, s7[1]};
    return e;
  endfunction

  function automatic instr_t mkI(input logic [1:0] cls, input logic br, input logic gr);
    instr_t i;
    i.cls = cls;
    i.br  = br;
    i.gr  = gr;
    return i;
  endfunction

  // One instruction expands into the list of cycles it should occupy, from the cycle-count rules.
  task automatic buildTrace(input int d);
    instr_t ins;
    logic   isBr;
    logic   isSt;
    ins  = cur[d];
    isBr = (ins.cls == C_BR);
    isSt = (ins.cls == C_ST);
    for (int k = 0; k < iLat(d); k++)
      expQ[d].push_back(mk(3'd0, {1'b1, (k == iLat(d) - 1), 5'b0}));
    expQ[d].push_back(mk(3'd1, 7'b0));
    expQ[d].push_back(mk(3'd2, {5'b0, isBr, isBr & ins.br}));
    if (ins.cls == C_LD || isSt)
      for (int k = 0; k < dLat(d); k++)
        expQ[d].push_back(mk(3'd3, {2'b0, 1'b1, isSt && (k == 0), 1'b0, isSt && (k == dLat(d) - 1), 1'b0}));
    if (!isBr && !isSt)
      expQ[d].push_back(mk(3'd4, {4'b0, ins.gr, 1'b1, ins.br}));
  endtask

  task automatic refill();
    instr_t ins;
    for (int d = 0; d < 2; d++) begin
      if (expQ[d].size() == 0) begin
        if (dirIdx[d] < dirList.size()) begin
          ins = dirList[dirIdx[d]];
          dirIdx[d]++;
        end else begin
          ins.cls = 2'($urandom_range(0, 3));
          ins.br  = 1'($urandom_range(0, 1));
          ins.gr  = (ins.cls == C_ST) ? 1'($urandom_range(0, 1)) : (ins.cls != C_BR);
        end
        cur[d] = ins;
        buildTrace(d);
      end
    end
  endtask

  // Decode bits are only promised from ID onward, so IF cycles see noise.
  task automatic applyStimulus(input int d, input logic stl);
    stallIn[d] = stl;
    if (expQ[d][0].st == 3'd0) begin
      isLoad[d]  = 1'($urandom_range(0, 1));
      isStore[d] = 1'($urandom_range(0, 1));
      grWe[d]    = 1'($urandom_range(0, 1));
      brTk[d]    = 1'($urandom_range(0, 1));
    end else begin
      isLoad[d]  = (cur[d].cls == C_LD);
      isStore[d] = (cur[d].cls == C_ST);
      grWe[d]    = cur[d].gr;
      brTk[d]    = cur[d].br;
    end
  endtask

  task automatic checkOne(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s dut%0d cycle=%0d observed=%h expected=%h", tag, d, cycleNo, obs, exp);
    end
  endtask

  task automatic checkOutput(input int d, input logic rst, input logic stl);
    exp_t       e;
    logic [7:0] obs;
    logic [7:0] expS;
    e    = expQ[d][0];
    obs  = {ifEnO[d], irWeO[d], dEnO[d], dWeO[d], rfWeO[d], pcWeO[d], pcSelO[d], retO[d]};
    expS = (rst || stl) ? 8'h00 : e.strb;
    if (!expS[2]) obs[1] = 1'b0;
    checkOne("state", d, {29'b0, stO[d]}, {29'b0, e.st});
    checkOne("strobes", d, {24'b0, obs}, {24'b0, expS});
`ifdef MC_CTRL_PERF_EN
    checkOne("cycle_cnt", d, cycO[d], expCyc[d]);
    checkOne("instret_cnt", d, insO[d], expRet[d]);
`else
    checkOne("cycle_cnt", d, cycO[d], 32'h0);
    checkOne("instret_cnt", d, insO[d], 32'h0);
`endif
  endtask

  task automatic runCycle(input logic rst, input logic s0, input logic s1);
    logic stl [2];
    stl[0]  = s0;
    stl[1]  = s1;
    resetIn = rst;
    refill();
    for (int d = 0; d < 2; d++) applyStimulus(d, stl[d]);
    @(negedge clk);
    if (modelValid)
      for (int d = 0; d < 2; d++) checkOutput(d, rst, stl[d]);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        expQ[d].delete();
        expCyc[d] = 32'h0;
        expRet[d] = 32'h0;
      end else begin
        expCyc[d] = expCyc[d] + 32'h1;
        if (!stl[d]) begin
          if (expQ[d][0].strb[2]) expRet[d] = expRet[d] + 32'h1;
          void'(expQ[d].pop_front());
        end
      end
    end
    if (rst) modelValid = 1'b1;
    cycleNo++;
  endtask

  initial begin
    logic done [2];
    logic s1;
    logic hit;
    int   n;
    int   stallsDone;
    checks     = 0;
    failures   = 0;
    cycleNo    = 0;
    modelValid = 1'b0;
    dirIdx[0]  = 0;
    dirIdx[1]  = 0;
    expCyc[0]  = 32'h0;
    expCyc[1]  = 32'h0;
    expRet[0]  = 32'h0;
    expRet[1]  = 32'h0;
    resetIn    = 1'b1;

    runCycle(1'b1, 1'b0, 1'b0);
    runCycle(1'b1, 1'b0, 1'b0);

    // add.w, jirl, ld.w, st.w, beq taken, bne not taken
    dirList.push_back(mkI(C_GR, 1'b0, 1'b1));
    dirList.push_back(mkI(C_GR, 1'b1, 1'b1));
    dirList.push_back(mkI(C_LD, 1'b0, 1'b1));
    dirList.push_back(mkI(C_ST, 1'b0, 1'b0));
    dirList.push_back(mkI(C_BR, 1'b1, 1'b0));
    dirList.push_back(mkI(C_BR, 1'b0, 1'b0));
    done[0] = 1'b0;
    done[1] = 1'b0;
    n = 0;
    while (!(done[0] && done[1]) && n < 300) begin
      runCycle(1'b0, 1'b0, 1'b0);
      n++;
      for (int d = 0; d < 2; d++)
        if (dirIdx[d] == dirList.size() && expQ[d].size() == 0) done[d] = 1'b1;
    end
    checkOne("directed_timeout", 0, {31'b0, done[0] && done[1]}, 32'h1);

    // Store on the DMEM_LAT=2 instance, stalled for 3 cycles on its last MEM cycle
    dirList.push_back(mkI(C_ST, 1'b1, 1'b0));
    stallsDone = 0;
    n = 0;
    while (!(stallsDone == 3 && expQ[1].size() == 0) && n < 200) begin
      refill();
      s1 = (stallsDone < 3) && (dirIdx[1] == dirList.size()) &&
           (expQ[1][0].st == 3'd3) && expQ[1][0].strb[2];
      if (s1) stallsDone++;
      runCycle(1'b0, 1'b0, s1);
      n++;
    end
    checkOne("stall_timeout", 1, stallsDone, 3);

    // Reset pulsed while the first instance sits in EXE
    hit = 1'b0;
    n = 0;
    while (!hit && n < 50) begin
      refill();
      if (expQ[0][0].st == 3'd2) begin
        runCycle(1'b1, 1'b0, 1'b0);
        hit = 1'b1;
      end else begin
        runCycle(1'b0, 1'b0, 1'b0);
      end
      n++;
    end
    checkOne("reset_exe_timeout", 0, {31'b0, hit}, 32'h1);
    runCycle(1'b0, 1'b0, 1'b0);
    runCycle(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 4000; i++)
      runCycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
